// File: rtl/mem_if_pkg.sv
// Shared definitions for the L1 <-> main-memory line-transfer interface.
package mem_if_pkg;

  // Words per cache line; ACK codes are 4 bits wide regardless.
  localparam int WORDS_PER_LINE = 8;

  // ACK code meaning "no word presented / consumed".
  localparam logic [3:0] ACK_NONE = 4'hF;

  // Load requests are aligned down to the 32-byte line boundary.
  localparam logic [31:0] LINE_ADDR_MASK = ~32'h1F;

  // Request controller states.
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    LD_DATA,
    LD_DONE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/l1_line_buffer.sv
// Line staging buffer: words are written one at a time by index while a fill
// is in flight, and copied into the visible line only on commit, so an
// aborted fill never disturbs the previously delivered line.
module l1_line_buffer #(
  parameter int DATA_W = 32,
  parameter int WORDS  = 8,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic                    commit_i,
  output logic [WORDS*DATA_W-1:0] line_data_o
);

  logic [DATA_W-1:0]       stage_q [WORDS];
  logic [WORDS*DATA_W-1:0] stage_flat;
  logic [WORDS*DATA_W-1:0] line_q;

  // Staging register: one word per write strobe, addressed by the memory ACK index.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WORDS; i++) stage_q[i] <= '0;
    end else if (wr_en_i) begin
      stage_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Flatten staging into line layout: word i at bits [i*DATA_W +: DATA_W].
  always_comb begin
    stage_flat = '0;
    for (int i = 0; i < WORDS; i++) stage_flat[i*DATA_W +: DATA_W] = stage_q[i];
  end

  // Visible line: updated only when a complete fill is committed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) line_q <= '0;
    else if (commit_i) line_q <= stage_flat;
  end

  assign line_data_o = line_q;

endmodule

// File: rtl/l1_mem_request_ctrl.sv
// L1-side initiator for the main-memory line-transfer protocol. Takes one
// load (line fill) or store (write-through) request from the L1 controller,
// sequences VALID/LOAD/STORE/ACK_ADDR/ACK_DATA_L1 toward memory, assembles the
// fill into the line buffer and reports done/error back to L1.
//
// Handshakes:
//   L1 side  : a request transfers on a rising edge where req_valid && req_ready;
//              req_ready is high only in IDLE, req_valid elsewhere is ignored.
//   Mem side : VALID+LOAD/STORE open a transaction, READY=1 grants it, ACK_ADDR
//              marks the address on MEM_DATA_OUT, ACK_DATA_MEM/ACK_DATA_L1 step
//              word indices (4'hF = none), READY=0 closes the transaction.
module l1_mem_request_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic                             req_valid,
  input  logic                             req_store,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic [DATA_W-1:0]                req_wdata,
  output logic                             req_ready,
  output logic [WORDS_PER_LINE*DATA_W-1:0] line_data,
  output logic                             resp_done,
  output logic                             resp_err,
  output logic                             VALID,
  output logic                             LOAD,
  output logic                             STORE,
  input  logic                             READY,
  output logic [DATA_W-1:0]                MEM_DATA_OUT,
  output logic                             MEM_DATA_OE,
  input  logic [DATA_W-1:0]                MEM_DATA_IN,
  output logic                             ACK_ADDR,
  output logic [3:0]                       ACK_DATA_L1,
  input  logic [3:0]                       ACK_DATA_MEM,
  output logic [2:0]                       dbg_state_o
);

  import mem_if_pkg::state_e;
  import mem_if_pkg::IDLE;
  import mem_if_pkg::REQ;
  import mem_if_pkg::ADDR;
  import mem_if_pkg::LD_DATA;
  import mem_if_pkg::LD_DONE;
  import mem_if_pkg::ST_DONE;
  import mem_if_pkg::ACK_NONE;
  import mem_if_pkg::LINE_ADDR_MASK;

  localparam int         IDX_W      = $clog2(WORDS_PER_LINE);
  localparam int         TW         = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAST_IDX   = 4'(WORDS_PER_LINE - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_store_q, is_store_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                valid_q, valid_d;
  logic                load_q, load_d;
  logic                store_q, store_d;
  logic                ack_addr_q, ack_addr_d;
  logic                oe_q, oe_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [3:0]          ack_l1_q, ack_l1_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                buf_wr;
  logic [IDX_W-1:0]    buf_idx;
  logic                buf_commit;

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_store_q <= 1'b0;
      timer_q    <= '0;
      valid_q    <= 1'b0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      ack_addr_q <= 1'b0;
      oe_q       <= 1'b0;
      dout_q     <= '0;
      ack_l1_q   <= ACK_NONE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_store_q <= is_store_d;
      timer_q    <= timer_d;
      valid_q    <= valid_d;
      load_q     <= load_d;
      store_q    <= store_d;
      ack_addr_q <= ack_addr_d;
      oe_q       <= oe_d;
      dout_q     <= dout_d;
      ack_l1_q   <= ack_l1_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state and next-output logic, with timeout abort overriding everything.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_store_d = is_store_q;
    valid_d    = valid_q;
    load_d     = load_q;
    store_d    = store_q;
    ack_addr_d = ack_addr_q;
    oe_d       = oe_q;
    dout_d     = dout_q;
    ack_l1_d   = ack_l1_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    buf_wr     = 1'b0;
    buf_idx    = '0;
    buf_commit = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d = req_store;
          addr_d     = req_store ? req_addr : (req_addr & ADDR_W'(LINE_ADDR_MASK));
          wdata_d    = req_wdata;
          valid_d    = 1'b1;
          load_d     = !req_store;
          store_d    = req_store;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (READY) begin
          dout_d     = DATA_W'(addr_q);
          oe_d       = 1'b1;
          ack_addr_d = 1'b1;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (ACK_DATA_MEM == 4'h0) begin
          ack_addr_d = 1'b0;
          ack_l1_d   = 4'h0;
          if (is_store_q) begin
            dout_d  = wdata_q;
            state_d = ST_DONE;
          end else begin
            buf_wr  = 1'b1;
            oe_d    = 1'b0;
            state_d = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        // Only the next expected index is accepted; stale or repeated codes hold.
        if (ACK_DATA_MEM == ack_l1_q + 4'd1) begin
          buf_wr   = 1'b1;
          buf_idx  = ACK_DATA_MEM[IDX_W-1:0];
          ack_l1_d = ACK_DATA_MEM;
          if (ACK_DATA_MEM == LAST_IDX) state_d = LD_DONE;
        end
      end
      LD_DONE: begin
        if (!READY) begin
          valid_d    = 1'b0;
          load_d     = 1'b0;
          ack_l1_d   = ACK_NONE;
          done_d     = 1'b1;
          buf_commit = 1'b1;
          state_d    = IDLE;
        end
      end
      ST_DONE: begin
        if (!READY) begin
          valid_d  = 1'b0;
          store_d  = 1'b0;
          oe_d     = 1'b0;
          ack_l1_d = ACK_NONE;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort on the cycle that would bring the dwell counter to TIMEOUT_CYCLES.
    if (state_q != IDLE && state_d == state_q && timer_q == TIMER_LAST) begin
      valid_d    = 1'b0;
      load_d     = 1'b0;
      store_d    = 1'b0;
      ack_addr_d = 1'b0;
      oe_d       = 1'b0;
      dout_d     = '0;
      ack_l1_d   = ACK_NONE;
      err_d      = 1'b1;
      buf_wr     = 1'b0;
      buf_commit = 1'b0;
      state_d    = IDLE;
    end

    timer_d = (state_d != state_q || state_d == IDLE) ? '0 : timer_q + 1'b1;
  end

  l1_line_buffer #(
    .DATA_W (DATA_W),
    .WORDS  (WORDS_PER_LINE),
    .IDX_W  (IDX_W)
  ) u_line_buffer (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .wr_en_i     (buf_wr),
    .wr_idx_i    (buf_idx),
    .wr_data_i   (MEM_DATA_IN),
    .commit_i    (buf_commit),
    .line_data_o (line_data)
  );

  assign req_ready    = (state_q == IDLE);
  assign resp_done    = done_q;
  assign resp_err     = err_q;
  assign VALID        = valid_q;
  assign LOAD         = load_q;
  assign STORE        = store_q;
  assign MEM_DATA_OUT = dout_q;
  assign MEM_DATA_OE  = oe_q;
  assign ACK_ADDR     = ack_addr_q;
  assign ACK_DATA_L1  = ack_l1_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_l1_mem_request_ctrl.sv
// Bench for l1_mem_request_ctrl: behavioural main-memory responder, a golden
// word array as reference, a table of directed transactions, random traffic,
// and hand-written timeout / reset / back-to-back sequences.
module tb_l1_mem_request_ctrl;

  localparam int TO = 1024;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_store = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic         req_ready;
  logic [255:0] line_data;
  logic         resp_done, resp_err;
  logic         VALID, LOAD, STORE;
  logic         READY;
  logic [31:0]  MEM_DATA_OUT;
  logic         MEM_DATA_OE;
  logic [31:0]  MEM_DATA_IN;
  logic         ACK_ADDR;
  logic [3:0]   ACK_DATA_L1;
  logic [3:0]   ACK_DATA_MEM;
  logic [2:0]   dbg_state_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  logic [31:0] mem    [256];   // responder storage (written by observed stores)
  logic [31:0] golden [256];   // reference memory (written by the driver)
  logic [31:0] last_line [8];

  bit          never_ready = 1'b0;
  int          stall_len = 0;
  int          stall_cnt = 0;
  logic [3:0]  prev_l1 = 4'hF;
  logic [31:0] cur_addr = '0;

  typedef struct {
    bit          st;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall;
    int          exp_lat;
  } vec_t;
  vec_t vecs [6];

  l1_mem_request_ctrl dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .req_valid    (req_valid),
    .req_store    (req_store),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .line_data    (line_data),
    .resp_done    (resp_done),
    .resp_err     (resp_err),
    .VALID        (VALID),
    .LOAD         (LOAD),
    .STORE        (STORE),
    .READY        (READY),
    .MEM_DATA_OUT (MEM_DATA_OUT),
    .MEM_DATA_OE  (MEM_DATA_OE),
    .MEM_DATA_IN  (MEM_DATA_IN),
    .ACK_ADDR     (ACK_ADDR),
    .ACK_DATA_L1  (ACK_DATA_L1),
    .ACK_DATA_MEM (ACK_DATA_MEM),
    .dbg_state_o  (dbg_state_o)
  );

  // Clock.
  always #5 CLK = ~CLK;

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory responder: grants while VALID, acks the address at once, presents
  // the next fill word after stall_len idle cycles (showing stale / none codes
  // meanwhile), and drops READY once the last word or the store data is out.
  always_comb begin
    READY        = 1'b0;
    ACK_DATA_MEM = 4'hF;
    if (VALID && !never_ready) begin
      READY = 1'b1;
      if (LOAD && ACK_DATA_L1 == 4'd7) READY = 1'b0;
      if (STORE && ACK_DATA_L1 == 4'd0) READY = 1'b0;
    end
    if (ACK_ADDR) begin
      ACK_DATA_MEM = 4'h0;
    end else if (LOAD && ACK_DATA_L1 < 4'd7) begin
      if (stall_cnt >= stall_len) ACK_DATA_MEM = ACK_DATA_L1 + 4'd1;
      else ACK_DATA_MEM = stall_cnt[0] ? 4'hF : ACK_DATA_L1;
    end
    MEM_DATA_IN = mem[{cur_addr[9:5], ACK_DATA_MEM[2:0]}];
  end

  // Stall counter: cycles since ACK_DATA_L1 last changed.
  always @(negedge CLK) begin
    if (ACK_DATA_L1 != prev_l1) stall_cnt <= 0;
    else stall_cnt <= stall_cnt + 1;
    prev_l1 <= ACK_DATA_L1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: unexpected value %h with empty scoreboard", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  // Memory-side monitor: address phase and store data phase against the scoreboard.
  always @(negedge CLK) begin
    if (ACK_ADDR) begin
      cur_addr <= MEM_DATA_OUT;
      sb_pop("mem_addr", MEM_DATA_OUT);
    end
    if (STORE && MEM_DATA_OE && ACK_DATA_L1 == 4'h0) begin
      mem[cur_addr[9:2]] = MEM_DATA_OUT;
      sb_pop("mem_store_data", MEM_DATA_OUT);
    end
  end

  task automatic check_line(input string tag, input logic [31:0] addr);
    logic [7:0] gi;
    for (int i = 0; i < 8; i++) begin
      gi = {addr[9:5], 3'(i)};
      check($sformatf("%s line word%0d", tag, i), line_data[i*32 +: 32], golden[gi]);
      last_line[i] = golden[gi];
    end
  endtask

  task automatic start_req(input bit st, input logic [31:0] addr, input logic [31:0] data,
                           input int stall);
    @(posedge CLK); #1;
    stall_len = stall;
    if (st) begin
      exp_q.push_back(addr);
      exp_q.push_back(data);
    end else begin
      exp_q.push_back(addr & ~32'h1F);
    end
    req_valid = 1'b1;
    req_store = st;
    req_addr  = addr;
    req_wdata = data;
  endtask

  task automatic wait_done(inout int cyc);
    while (resp_done !== 1'b1 && cyc < 400) begin
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic run_txn(input bit st, input logic [31:0] addr, input logic [31:0] data,
                         input int stall, input int exp_lat, input string tag);
    int cyc;
    start_req(st, addr, data, stall);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    cyc = 1;
    wait_done(cyc);
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " done"}, resp_done, 1'b1);
    check({tag, " err_quiet"}, resp_err, 1'b0);
    check({tag, " valid_low"}, VALID, 1'b0);
    check({tag, " ack_l1_none"}, ACK_DATA_L1, 4'hF);
    check({tag, " ready_idle"}, req_ready, 1'b1);
    if (st) begin
      check({tag, " store_low"}, STORE, 1'b0);
      golden[addr[9:2]] = data;
    end else begin
      check({tag, " load_low"}, LOAD, 1'b0);
      check_line(tag, addr);
    end
    check({tag, " sb_drain"}, exp_q.size(), 0);
    @(posedge CLK); #1;
    check({tag, " done_pulse"}, resp_done, 1'b0);
  endtask

  initial begin
    int n;
    int dn;
    int cyc;
    bit st;
    int stall;
    logic [31:0] addr;

    vecs[0] = '{st: 1'b0, addr: 32'h0000_0044, data: 32'h0,          stall: 0, exp_lat: 11};
    vecs[1] = '{st: 1'b0, addr: 32'h0000_0044, data: 32'h0,          stall: 3, exp_lat: 32};
    vecs[2] = '{st: 1'b1, addr: 32'h0000_0100, data: 32'hDEAD_BEEF,  stall: 0, exp_lat: 4};
    vecs[3] = '{st: 1'b1, addr: 32'h0000_0058, data: 32'h1234_5678,  stall: 0, exp_lat: 4};
    vecs[4] = '{st: 1'b0, addr: 32'h0000_005C, data: 32'h0,          stall: 0, exp_lat: 11};
    vecs[5] = '{st: 1'b0, addr: 32'h0000_0104, data: 32'h0,          stall: 2, exp_lat: 25};

    for (int i = 0; i < 256; i++) begin
      mem[i]    = $urandom;
      golden[i] = mem[i];
    end
    for (int i = 0; i < 8; i++) last_line[i] = '0;

    // Reset and reset-state checks.
    repeat (3) @(posedge CLK);
    #1;
    check("rst valid", VALID, 1'b0);
    check("rst ack_l1", ACK_DATA_L1, 4'hF);
    check("rst ready", req_ready, 1'b1);
    check("rst dout", MEM_DATA_OUT, 32'h0);
    check("rst oe", MEM_DATA_OE, 1'b0);
    check("rst done", resp_done, 1'b0);
    check("rst state", dbg_state_o, 3'd0);
    check("rst line_w0", line_data[31:0], 32'h0);
    check("rst line_w7", line_data[255:224], 32'h0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed table.
    for (int i = 0; i < 6; i++)
      run_txn(vecs[i].st, vecs[i].addr, vecs[i].data, vecs[i].stall, vecs[i].exp_lat,
              $sformatf("vec%0d", i));

    // Random traffic against the golden memory.
    for (int i = 0; i < 20; i++) begin
      st    = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      if (st) addr = 32'($urandom_range(0, 255)) << 2;
      else addr = 32'($urandom_range(0, 1023));
      run_txn(st, addr, $urandom, stall, st ? 4 : 11 + 7 * stall, $sformatf("rnd%0d", i));
    end

    // Memory never grants: abort after TO cycles in REQ, line kept.
    never_ready = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b1;
    req_store = 1'b0;
    req_addr  = 32'h0000_0080;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("to valid_up", VALID, 1'b1);
    n  = 0;
    dn = 0;
    while (resp_err !== 1'b1 && n < TO + 50) begin
      @(posedge CLK); #1;
      n++;
      if (resp_done) dn++;
    end
    check("to cycles", n, TO);
    check("to no_done", dn, 0);
    check("to valid_low", VALID, 1'b0);
    check("to load_low", LOAD, 1'b0);
    check("to ack_l1", ACK_DATA_L1, 4'hF);
    check("to oe", MEM_DATA_OE, 1'b0);
    check("to ready", req_ready, 1'b1);
    for (int i = 0; i < 8; i++)
      check($sformatf("to line_kept w%0d", i), line_data[i*32 +: 32], last_line[i]);
    @(posedge CLK); #1;
    check("to err_pulse", resp_err, 1'b0);
    never_ready = 1'b0;

    // Reset in the middle of a fill at word 4.
    start_req(1'b0, 32'h0000_02C4, 32'h0, 3);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    n = 0;
    while (ACK_DATA_L1 !== 4'd4 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    check("mr reach_w4", ACK_DATA_L1, 4'd4);
    #2 RST_N = 1'b0;
    #1;
    check("mr valid", VALID, 1'b0);
    check("mr load", LOAD, 1'b0);
    check("mr ack_addr", ACK_ADDR, 1'b0);
    check("mr oe", MEM_DATA_OE, 1'b0);
    check("mr ack_l1", ACK_DATA_L1, 4'hF);
    check("mr dout", MEM_DATA_OUT, 32'h0);
    check("mr line_w0", line_data[31:0], 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    dn = 0;
    repeat (15) begin
      @(posedge CLK); #1;
      if (resp_done) dn++;
    end
    check("mr no_done", dn, 0);
    run_txn(1'b0, 32'h0000_02C4, 32'h0, 0, 11, "post_rst");

    // Back-to-back loads with req_valid held high.
    @(posedge CLK); #1;
    stall_len = 0;
    exp_q.push_back(32'h0000_0200);
    req_valid = 1'b1;
    req_store = 1'b0;
    req_addr  = 32'h0000_0204;
    @(posedge CLK); #1;
    check("b2b busy_ready", req_ready, 1'b0);
    req_addr = 32'h0000_02A8;
    exp_q.push_back(32'h0000_02A0);
    cyc = 1;
    wait_done(cyc);
    check("b2b lat1", cyc, 11);
    check("b2b ready_at_done", req_ready, 1'b1);
    check("b2b valid_at_done", VALID, 1'b0);
    check_line("b2b1", 32'h0000_0200);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("b2b accept", VALID, 1'b1);
    check("b2b done_pulse", resp_done, 1'b0);
    cyc = 1;
    wait_done(cyc);
    check("b2b lat2", cyc, 11);
    check_line("b2b2", 32'h0000_02A0);

    repeat (3) @(posedge CLK);
    check("final sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l1_mem_request_ctrl.md
Name: l1_mem_request_ctrl

Overview:
- L1-side initiator for the main-memory line-transfer protocol.
- Accepts one miss-fill (load) or write-through (store) request from the L1 cache controller and drives VALID/LOAD/STORE/ACK_ADDR/ACK_DATA_L1 toward main memory.
- Assembles the 8-word fill into a line buffer and reports completion back to L1.
- Sits between the L1 cache FSM and Main_Memory; it is the only master on the memory interface.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width on the memory data bus.
- WORDS_PER_LINE, 8, words per cache line (index width 3; ACK codes are 4 bits).
- TIMEOUT_CYCLES, 1024, maximum cycles spent waiting in any state before aborting with error.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- req_valid  in  1  L1 request strobe, sampled only in IDLE.
- req_store  in  1  1 = store, 0 = line load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  high in IDLE only.
- line_data  out  WORDS_PER_LINE*DATA_W  filled line; word i occupies bits [i*DATA_W +: DATA_W]; held until the next load completes.
- resp_done  out  1  one-cycle pulse on successful completion.
- resp_err  out  1  one-cycle pulse on timeout abort.
- VALID  out  1  transaction active toward memory.
- LOAD  out  1  load transaction.
- STORE  out  1  store transaction.
- READY  in  1  memory accepts the transaction.
- MEM_DATA_OUT  out  DATA_W  address or store data toward memory.
- MEM_DATA_OE  out  1  high while MEM_DATA_OUT is driven; the top level builds the DATA tristate.
- MEM_DATA_IN  in  DATA_W  data from memory.
- ACK_ADDR  out  1  address present on MEM_DATA_OUT.
- ACK_DATA_L1  out  4  index of the last word consumed or sent; 4'hF = none.
- ACK_DATA_MEM  in  4  index of the word memory has presented or accepted; 4'hF = none.

Behaviour:
- Reset (asynchronous, RST_N low): state IDLE. VALID, LOAD, STORE, ACK_ADDR, MEM_DATA_OE, resp_done, resp_err = 0. ACK_DATA_L1 = 4'hF. MEM_DATA_OUT = 0. line_data = 0. Word counter and timeout counter = 0. req_ready is 1 after reset.
- Reset mid-transaction: all memory-side outputs drop immediately. No completion pulse is issued.
- Latched request: address is line-aligned for loads (req_addr & ~32'h1F); stores use req_addr unmodified. Store data is latched with the request.
- IDLE: req_ready = 1. On req_valid, latch the request, raise VALID plus LOAD or STORE, and go to REQ.
- REQ: wait for READY = 1. Then drive MEM_DATA_OUT = address, MEM_DATA_OE = 1, ACK_ADDR = 1, and go to ADDR.
- ADDR: wait for ACK_DATA_MEM == 4'h0. Then drop ACK_ADDR.
  - Load: capture MEM_DATA_IN into word 0, set ACK_DATA_L1 = 0, MEM_DATA_OE = 0, and go to LD_DATA.
  - Store: drive MEM_DATA_OUT = wdata, set ACK_DATA_L1 = 0, and go to ST_DONE.
- LD_DATA: expected index k = ACK_DATA_L1 + 1.
  - When ACK_DATA_MEM == k, capture word k and set ACK_DATA_L1 = k.
  - Any other ACK_DATA_MEM value (stale, repeated or 4'hF): hold, no capture.
  - After word 7 is captured, go to LD_DONE.
- LD_DONE: wait for READY = 0. Then VALID = LOAD = 0, ACK_DATA_L1 = 4'hF, resp_done = 1 for one cycle, and go to IDLE.
- ST_DONE: wait for READY = 0. Then VALID = STORE = 0, MEM_DATA_OE = 0, ACK_DATA_L1 = 4'hF, resp_done pulse, and go to IDLE.
- Timing: one transition per cycle; outputs are registered.
  - Minimum load latency from req_valid to resp_done: 1 (REQ) + 1 (ADDR) + 1 (word 0) + 7 (words 1–7) + 1 (READY low) = 11 cycles, with memory responding each cycle.
- Timeout: the counter clears on every state change and increments otherwise. Reaching TIMEOUT_CYCLES in any non-IDLE state aborts:
  - all memory-side outputs return to reset values;
  - resp_err pulses for one cycle;
  - state returns to IDLE;
  - line_data is not updated on abort; the staging buffer is committed only at LD_DONE.
- req_valid while not IDLE is ignored (req_ready = 0).

Decomposition:
- Shared package mem_if_pkg:
  - state enum (IDLE, REQ, ADDR, LD_DATA, LD_DONE, ST_DONE);
  - ACK_NONE = 4'hF;
  - LINE_ADDR_MASK = ~32'h1F;
  - WORDS_PER_LINE.
- One sub-module, l1_line_buffer: an 8-entry staging register with a write index and a commit strobe that copies staging into line_data.

Test Plan:
- Load, ideal memory (one word per cycle, addr 0x0000_0044): ACK_ADDR drops after ACK_DATA_MEM = 0; ACK_DATA_L1 steps 0..7; resp_done 11 cycles after req_valid; line_data words = mem[0x40..0x5C]; ACK_DATA_L1 returns to F.
- Load with memory stalling 3 cycles between words and repeating ACK_DATA_MEM = 2: no duplicate capture; line_data is correct; ACK_DATA_L1 is never ahead of ACK_DATA_MEM.
- Store addr 0x100, data 0xDEADBEEF: MEM_DATA_OUT = 0x100 while ACK_ADDR = 1, then 0xDEADBEEF with ACK_DATA_L1 = 0; resp_done after READY falls; STORE deasserts.
- Memory never raises READY: resp_err exactly TIMEOUT_CYCLES cycles after entering REQ; VALID = 0; ACK_DATA_L1 = F; previous line_data is unchanged.
- RST_N pulsed low at word 4 of a load: outputs are at reset values in the same cycle; no resp_done; the next load completes normally.
- req_valid held high across back-to-back loads: the second request is accepted only in the cycle after resp_done (req_ready = 1).
